// File: rtl/five_tuple_lookup_pkg.sv
// Shared definitions for the five-tuple flow lookup: FSM encoding, field
// layout of the 104-bit tuple, datapath widths and the drop-counter ceiling.
package five_tuple_lookup_pkg;

  // Datapath widths
  localparam int TUPLE_W    = 104;
  localparam int TAG_W      = 48;
  localparam int BUFID_W    = 9;
  localparam int DROP_CNT_W = 16;

  // Drop counter sticks here instead of wrapping
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  // Field positions inside the tuple, MSB first
  localparam int PROTO_MSB = 103;
  localparam int PROTO_LSB = 96;
  localparam int SIP_MSB   = 95;
  localparam int SIP_LSB   = 64;
  localparam int DIP_MSB   = 63;
  localparam int DIP_LSB   = 32;
  localparam int SPORT_MSB = 31;
  localparam int SPORT_LSB = 16;
  localparam int DPORT_MSB = 15;
  localparam int DPORT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_OUTPUT = 2'd2
  } lookup_state_e;

  // Assemble a tuple from its fields using the layout above
  function automatic logic [TUPLE_W-1:0] make_tuple(
    input logic [7:0]  proto,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip,
    input logic [15:0] src_port,
    input logic [15:0] dst_port
  );
    logic [TUPLE_W-1:0] t;
    t                     = '0;
    t[PROTO_MSB:PROTO_LSB] = proto;
    t[SIP_MSB:SIP_LSB]     = src_ip;
    t[DIP_MSB:DIP_LSB]     = dst_ip;
    t[SPORT_MSB:SPORT_LSB] = src_port;
    t[DPORT_MSB:DPORT_LSB] = dst_port;
    return t;
  endfunction

endpackage

// File: rtl/five_tuple_lookup_flow_tbl.sv
// Flow table storage: one synchronous write port driven by configuration and
// one combinational read port addressed by the running search index.
module flow_tbl_regfile
  import five_tuple_lookup_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [AW-1:0]      iv_wr_addr,
  input  logic               i_wr_valid,
  input  logic [TUPLE_W-1:0] iv_wr_key,
  input  logic [TAG_W-1:0]   iv_wr_tag,
  input  logic [AW-1:0]      iv_rd_addr,
  output logic               o_rd_valid,
  output logic [TUPLE_W-1:0] ov_rd_key,
  output logic [TAG_W-1:0]   ov_rd_tag
);

  logic [DEPTH-1:0]   valid_q;
  logic [TUPLE_W-1:0] key_q [DEPTH];
  logic [TAG_W-1:0]   tag_q [DEPTH];

  // Valid bits: cleared by reset, updated by a configuration write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (i_wr) begin
      valid_q[iv_wr_addr] <= i_wr_valid;
    end
  end

  // Key/tag payload storage
  // NOTE: only the valid bits are reset; key and tag are never read as a hit
  // while their entry is invalid, so the payload array stays reset-free.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      key_q[iv_wr_addr] <= iv_wr_key;
      tag_q[iv_wr_addr] <= iv_wr_tag;
    end
  end

  // Read returns current contents, so a same-cycle write is not yet visible
  assign o_rd_valid = valid_q[iv_rd_addr];
  assign ov_rd_key  = key_q[iv_rd_addr];
  assign ov_rd_tag  = tag_q[iv_rd_addr];

endmodule

// File: rtl/five_tuple_lookup.sv
// Five-tuple flow lookup: accepts one request at a time, walks the flow table
// one entry per cycle for TCP/UDP traffic, and presents a held descriptor
// carrying either the matched TSN tag or the request DMAC until acknowledged.
module five_tuple_lookup
  import five_tuple_lookup_pkg::*;
#(
  parameter int TBL_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [TUPLE_W-1:0]           iv_5tuple_data,
  input  logic                         i_5tuple_data_wr,
  input  logic [TAG_W-1:0]             iv_dmac,
  input  logic [BUFID_W-1:0]           iv_bufid,
  input  logic                         i_tcp_or_udp_flag,
  input  logic                         i_cfg_wr,
  input  logic [$clog2(TBL_DEPTH)-1:0] iv_cfg_addr,
  input  logic                         i_cfg_valid,
  input  logic [TUPLE_W-1:0]           iv_cfg_key,
  input  logic [TAG_W-1:0]             iv_cfg_tag,
  output logic [TAG_W-1:0]             ov_tsntag,
  output logic [BUFID_W-1:0]           ov_bufid,
  output logic                         o_hit,
  output logic                         o_descriptor_wr,
  input  logic                         i_descriptor_ack,
  output logic [DROP_CNT_W-1:0]        ov_drop_cnt
);

  localparam int            AW       = $clog2(TBL_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(TBL_DEPTH - 1);

  lookup_state_e      state_q;
  logic [AW-1:0]      idx_q;
  logic [TUPLE_W-1:0] key_q;
  logic [TAG_W-1:0]   dmac_q;
  logic [BUFID_W-1:0] bufid_q;

  logic [TAG_W-1:0]   tsntag_q;
  logic [BUFID_W-1:0] out_bufid_q;
  logic               hit_q;
  logic               desc_wr_q;

  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;

  logic               rd_valid;
  logic [TUPLE_W-1:0] rd_key;
  logic [TAG_W-1:0]   rd_tag;
  logic               entry_hit;

  flow_tbl_regfile #(
    .DEPTH (TBL_DEPTH),
    .AW    (AW)
  ) u_flow_tbl (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr       (i_cfg_wr),
    .iv_wr_addr (iv_cfg_addr),
    .i_wr_valid (i_cfg_valid),
    .iv_wr_key  (iv_cfg_key),
    .iv_wr_tag  (iv_cfg_tag),
    .iv_rd_addr (idx_q),
    .o_rd_valid (rd_valid),
    .ov_rd_key  (rd_key),
    .ov_rd_tag  (rd_tag)
  );

  assign entry_hit = rd_valid && (rd_key == key_q);

  // Lookup FSM: capture request, scan table, hold descriptor until ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      key_q       <= '0;
      dmac_q      <= '0;
      bufid_q     <= '0;
      tsntag_q    <= '0;
      out_bufid_q <= '0;
      hit_q       <= 1'b0;
      desc_wr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_5tuple_data_wr) begin
            key_q   <= iv_5tuple_data;
            dmac_q  <= iv_dmac;
            bufid_q <= iv_bufid;
            idx_q   <= '0;
            if (i_tcp_or_udp_flag) begin
              state_q <= ST_SEARCH;
            end else begin
              // Non-TCP/UDP traffic never consults the table
              state_q     <= ST_OUTPUT;
              desc_wr_q   <= 1'b1;
              tsntag_q    <= iv_dmac;
              out_bufid_q <= iv_bufid;
              hit_q       <= 1'b0;
            end
          end
        end

        ST_SEARCH: begin
          if (entry_hit) begin
            state_q     <= ST_OUTPUT;
            desc_wr_q   <= 1'b1;
            tsntag_q    <= rd_tag;
            out_bufid_q <= bufid_q;
            hit_q       <= 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_q     <= ST_OUTPUT;
            desc_wr_q   <= 1'b1;
            tsntag_q    <= dmac_q;
            out_bufid_q <= bufid_q;
            hit_q       <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end

        ST_OUTPUT: begin
          if (i_descriptor_ack) begin
            state_q     <= ST_IDLE;
            desc_wr_q   <= 1'b0;
            tsntag_q    <= '0;
            out_bufid_q <= '0;
            hit_q       <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          desc_wr_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of requests arriving while busy
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_5tuple_data_wr && (state_q != ST_IDLE) && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Drop counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ov_tsntag       = tsntag_q;
  assign ov_bufid        = out_bufid_q;
  assign o_hit           = hit_q;
  assign o_descriptor_wr = desc_wr_q;
  assign ov_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_five_tuple_lookup.sv
// Randomized and directed bench for five_tuple_lookup against a table-walk
// reference model; inputs change and outputs are sampled on the falling edge.
module tb_five_tuple_lookup;
  import five_tuple_lookup_pkg::*;

  localparam int TBL_DEPTH = 8;
  localparam int AW        = $clog2(TBL_DEPTH);
  localparam int TIMEOUT   = 64;

  logic               i_clk;
  logic               i_rst;
  logic [TUPLE_W-1:0] iv_5tuple_data;
  logic               i_5tuple_data_wr;
  logic [TAG_W-1:0]   iv_dmac;
  logic [BUFID_W-1:0] iv_bufid;
  logic               i_tcp_or_udp_flag;
  logic               i_cfg_wr;
  logic [AW-1:0]      iv_cfg_addr;
  logic               i_cfg_valid;
  logic [TUPLE_W-1:0] iv_cfg_key;
  logic [TAG_W-1:0]   iv_cfg_tag;
  logic [TAG_W-1:0]   ov_tsntag;
  logic [BUFID_W-1:0] ov_bufid;
  logic               o_hit;
  logic               o_descriptor_wr;
  logic               i_descriptor_ack;
  logic [DROP_CNT_W-1:0] ov_drop_cnt;

  five_tuple_lookup #(.TBL_DEPTH(TBL_DEPTH)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .iv_5tuple_data    (iv_5tuple_data),
    .i_5tuple_data_wr  (i_5tuple_data_wr),
    .iv_dmac           (iv_dmac),
    .iv_bufid          (iv_bufid),
    .i_tcp_or_udp_flag (i_tcp_or_udp_flag),
    .i_cfg_wr          (i_cfg_wr),
    .iv_cfg_addr       (iv_cfg_addr),
    .i_cfg_valid       (i_cfg_valid),
    .iv_cfg_key        (iv_cfg_key),
    .iv_cfg_tag        (iv_cfg_tag),
    .ov_tsntag         (ov_tsntag),
    .ov_bufid          (ov_bufid),
    .o_hit             (o_hit),
    .o_descriptor_wr   (o_descriptor_wr),
    .i_descriptor_ack  (i_descriptor_ack),
    .ov_drop_cnt       (ov_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: table contents and expected drop count
  logic               m_valid [TBL_DEPTH];
  logic [TUPLE_W-1:0] m_key   [TBL_DEPTH];
  logic [TAG_W-1:0]   m_tag   [TBL_DEPTH];
  logic [DROP_CNT_W-1:0] exp_drop;

  logic [TUPLE_W-1:0] pool [4];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [TUPLE_W-1:0] rand_tuple();
    return make_tuple(8'($urandom()), $urandom(), $urandom(), 16'($urandom()), 16'($urandom()));
  endfunction

  function automatic logic [TAG_W-1:0] rand48();
    return TAG_W'({$urandom(), $urandom()});
  endfunction

  function automatic void bump_drop();
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
  endfunction

  // Latency/tag/hit from the table-walk rules: first valid matching entry wins
  function automatic void predict(input logic [TUPLE_W-1:0] key, input logic [TAG_W-1:0] dmac,
                                  input logic flag, output int lat,
                                  output logic [TAG_W-1:0] tag, output logic hit);
    bit found;
    found = 0;
    hit   = 1'b0;
    tag   = dmac;
    lat   = flag ? TBL_DEPTH + 1 : 1;
    if (flag) begin
      for (int k = 0; k < TBL_DEPTH; k++) begin
        if (!found && m_valid[k] && m_key[k] == key) begin
          found = 1;
          hit   = 1'b1;
          tag   = m_tag[k];
          lat   = k + 2;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < TBL_DEPTH; k++) m_valid[k] = 1'b0;
    exp_drop = '0;
  endtask

  task automatic cfg_write(input int addr, input logic v, input logic [TUPLE_W-1:0] key,
                           input logic [TAG_W-1:0] tag);
    @(negedge i_clk);
    i_cfg_wr    = 1'b1;
    iv_cfg_addr = AW'(addr);
    i_cfg_valid = v;
    iv_cfg_key  = key;
    iv_cfg_tag  = tag;
    @(negedge i_clk);
    i_cfg_wr     = 1'b0;
    m_valid[addr] = v;
    m_key[addr]   = key;
    m_tag[addr]   = tag;
  endtask

  // Present a request for one cycle (leaves the strobe high in cycle T)
  task automatic launch(input logic [TUPLE_W-1:0] key, input logic [TAG_W-1:0] dmac,
                        input logic [BUFID_W-1:0] bufid, input logic flag);
    @(negedge i_clk);
    iv_5tuple_data    = key;
    iv_dmac           = dmac;
    iv_bufid          = bufid;
    i_tcp_or_udp_flag = flag;
    i_5tuple_data_wr  = 1'b1;
  endtask

  // Launch, then count cycles until the descriptor appears (bounded)
  task automatic request(input logic [TUPLE_W-1:0] key, input logic [TAG_W-1:0] dmac,
                         input logic [BUFID_W-1:0] bufid, input logic flag, output int lat);
    launch(key, dmac, bufid, flag);
    @(negedge i_clk);
    i_5tuple_data_wr = 1'b0;
    lat = 1;
    while (!o_descriptor_wr && lat < TIMEOUT) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic check_desc(input string name, input int lat, input int exp_lat,
                            input logic [TAG_W-1:0] tag, input logic [BUFID_W-1:0] bufid,
                            input logic hit);
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    check({name, "_desc_wr"}, 128'(o_descriptor_wr), 128'(1'b1));
    check({name, "_tag"}, 128'(ov_tsntag), 128'(tag));
    check({name, "_bufid"}, 128'(ov_bufid), 128'(bufid));
    check({name, "_hit"}, 128'(o_hit), 128'(hit));
  endtask

  // Acknowledge, optionally with a colliding request that must be dropped
  task automatic release_desc(input string name, input logic with_req);
    i_descriptor_ack = 1'b1;
    i_5tuple_data_wr = with_req;
    if (with_req) bump_drop();
    @(negedge i_clk);
    i_descriptor_ack = 1'b0;
    i_5tuple_data_wr = 1'b0;
    check({name, "_rel_desc_wr"}, 128'(o_descriptor_wr), 128'(1'b0));
    check({name, "_rel_tag"}, 128'(ov_tsntag), 128'(0));
    check({name, "_rel_bufid"}, 128'(ov_bufid), 128'(0));
    check({name, "_rel_hit"}, 128'(o_hit), 128'(1'b0));
    check({name, "_rel_drop"}, 128'(ov_drop_cnt), 128'(exp_drop));
  endtask

  initial begin
    logic [TUPLE_W-1:0] k_main, k2, k3, key;
    logic [TAG_W-1:0]   dmac, etag, tag_a;
    logic [BUFID_W-1:0] bufid;
    logic               flag, ehit, seen;
    int                 lat, elat, hold;

    i_rst = 1'b1;
    iv_5tuple_data = '0; i_5tuple_data_wr = 1'b0; iv_dmac = '0; iv_bufid = '0;
    i_tcp_or_udp_flag = 1'b0; i_cfg_wr = 1'b0; iv_cfg_addr = '0; i_cfg_valid = 1'b0;
    iv_cfg_key = '0; iv_cfg_tag = '0; i_descriptor_ack = 1'b0;
    exp_drop = '0;
    for (int k = 0; k < TBL_DEPTH; k++) begin
      m_valid[k] = 1'b0; m_key[k] = '0; m_tag[k] = '0;
    end
    for (int i = 0; i < 4; i++) pool[i] = rand_tuple();
    k_main = rand_tuple();
    k2     = k_main ^ 104'd1;
    k3     = k_main ^ 104'd2;

    repeat (2) @(negedge i_clk);
    do_reset();

    // Reset state
    check("rst_desc_wr", 128'(o_descriptor_wr), 128'(1'b0));
    check("rst_tag", 128'(ov_tsntag), 128'(0));
    check("rst_bufid", 128'(ov_bufid), 128'(0));
    check("rst_hit", 128'(o_hit), 128'(1'b0));
    check("rst_drop", 128'(ov_drop_cnt), 128'(0));

    // Hit at index 3: latency 5
    cfg_write(3, 1'b1, k_main, 48'h0000_1234_5678);
    request(k_main, rand48(), 9'h05, 1'b1, lat);
    check_desc("hit3", lat, 5, 48'h0000_1234_5678, 9'h05, 1'b1);
    release_desc("hit3", 1'b0);

    // All entries invalid: miss after full walk
    do_reset();
    request(k_main, 48'h0011_2233_4455, 9'h1A0, 1'b1, lat);
    check_desc("miss", lat, TBL_DEPTH + 1, 48'h0011_2233_4455, 9'h1A0, 1'b0);
    release_desc("miss", 1'b0);

    // Non-TCP/UDP: one-cycle latency, held 10 cycles, ack collides with request
    dmac = rand48();
    request(k_main, dmac, 9'h033, 1'b0, lat);
    check_desc("bypass", lat, 1, dmac, 9'h033, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("bypass_hold_wr", 128'(o_descriptor_wr), 128'(1'b1));
      check("bypass_hold_tag", 128'(ov_tsntag), 128'(dmac));
      check("bypass_hold_bufid", 128'(ov_bufid), 128'(9'h033));
    end
    release_desc("bypass", 1'b1);

    // Duplicate key at entries 1 and 6: lowest index wins
    cfg_write(1, 1'b1, k_main, 48'hAAAA_0000_0001);
    cfg_write(6, 1'b1, k_main, 48'hBBBB_0000_0006);
    request(k_main, rand48(), 9'h077, 1'b1, lat);
    check_desc("dup", lat, 3, 48'hAAAA_0000_0001, 9'h077, 1'b1);
    release_desc("dup", 1'b0);

    // Config write to the entry being compared uses the old contents
    tag_a = 48'hC0DE_0000_0002;
    cfg_write(2, 1'b1, k2, tag_a);
    launch(k2, rand48(), 9'h044, 1'b1);
    @(negedge i_clk);
    i_5tuple_data_wr = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_cfg_wr = 1'b1; iv_cfg_addr = AW'(2); i_cfg_valid = 1'b0; iv_cfg_key = k2; iv_cfg_tag = '0;
    @(negedge i_clk);
    i_cfg_wr = 1'b0;
    m_valid[2] = 1'b0;
    check_desc("wr_collide", 4, 4, tag_a, 9'h044, 1'b1);
    release_desc("wr_collide", 1'b0);
    dmac = rand48();
    request(k2, dmac, 9'h045, 1'b1, lat);
    check_desc("wr_after", lat, TBL_DEPTH + 1, dmac, 9'h045, 1'b0);
    release_desc("wr_after", 1'b0);

    // Three requests during SEARCH are dropped
    do_reset();
    dmac = rand48();
    launch(k3, dmac, 9'h0F0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_5tuple_data_wr = 1'b1;
      bump_drop();
    end
    @(negedge i_clk);
    i_5tuple_data_wr = 1'b0;
    lat = 4;
    while (!o_descriptor_wr && lat < TIMEOUT) begin
      @(negedge i_clk);
      lat++;
    end
    check_desc("drop3", lat, TBL_DEPTH + 1, dmac, 9'h0F0, 1'b0);
    check("drop3_cnt", 128'(ov_drop_cnt), 128'(16'd3));
    release_desc("drop3", 1'b0);

    // Reset during SEARCH aborts the request and clears the table
    cfg_write(5, 1'b1, k_main, rand48());
    launch(k_main, rand48(), 9'h011, 1'b1);
    @(negedge i_clk);
    i_5tuple_data_wr = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < TBL_DEPTH; k++) m_valid[k] = 1'b0;
    exp_drop = '0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge i_clk);
      seen = seen | o_descriptor_wr;
    end
    check("abort_no_desc", 128'(seen), 128'(1'b0));
    check("abort_drop", 128'(ov_drop_cnt), 128'(0));
    dmac = rand48();
    request(k_main, dmac, 9'h012, 1'b1, lat);
    check_desc("abort_miss", lat, TBL_DEPTH + 1, dmac, 9'h012, 1'b0);
    release_desc("abort_miss", 1'b0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(1) == 1)
        cfg_write(int'($urandom_range(TBL_DEPTH - 1)), $urandom_range(3) != 0,
                  pool[$urandom_range(3)], rand48());
      key   = ($urandom_range(4) == 0) ? rand_tuple() : pool[$urandom_range(3)];
      dmac  = rand48();
      bufid = BUFID_W'($urandom());
      flag  = $urandom_range(3) != 0;
      predict(key, dmac, flag, elat, etag, ehit);
      request(key, dmac, bufid, flag, lat);
      check_desc("rnd", lat, elat, etag, bufid, ehit);
      hold = int'($urandom_range(3));
      for (int i = 0; i < hold; i++) begin
        i_5tuple_data_wr = $urandom_range(1) == 1;
        if (i_5tuple_data_wr) bump_drop();
        @(negedge i_clk);
        i_5tuple_data_wr = 1'b0;
        check("rnd_hold_wr", 128'(o_descriptor_wr), 128'(1'b1));
        check("rnd_hold_tag", 128'(ov_tsntag), 128'(etag));
        check("rnd_hold_hit", 128'(o_hit), 128'(ehit));
      end
      release_desc("rnd", $urandom_range(1) == 1);
    end

    // Drop counter saturation, held in OUTPUT with a continuous request strobe
    do_reset();
    dmac = rand48();
    launch(k_main, dmac, 9'h1FF, 1'b0);
    @(negedge i_clk);
    repeat (65534) begin
      @(negedge i_clk);
      bump_drop();
    end
    check("sat_fffe", 128'(ov_drop_cnt), 128'(16'hFFFE));
    repeat (3) begin
      @(negedge i_clk);
      bump_drop();
    end
    check("sat_ffff", 128'(ov_drop_cnt), 128'(16'hFFFF));
    check("sat_model", 128'(exp_drop), 128'(16'hFFFF));
    check("sat_hold_tag", 128'(ov_tsntag), 128'(dmac));
    i_5tuple_data_wr = 1'b0;
    release_desc("sat", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/five_tuple_lookup.md
FIVE_TUPLE_LOOKUP -- requirements
Module: five_tuple_lookup

Interface
REQ-001 SHALL have parameter TBL_DEPTH, default 8: number of flow-table entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- iv_5tuple_data  in  104  {proto[103:96], src ip[95:64], dst ip[63:32], src port[31:16], dst port[15:0]}.
- i_5tuple_data_wr  in  1  one-cycle request strobe.
- iv_dmac  in  48  DMAC of the request.
- iv_bufid  in  9  buffer id of the request.
- i_tcp_or_udp_flag  in  1  request is TCP or UDP.
- i_cfg_wr  in  1  table write strobe.
- iv_cfg_addr  in  log2(TBL_DEPTH)  entry index.
- i_cfg_valid  in  1  entry valid bit.
- iv_cfg_key  in  104  entry 5-tuple.
- iv_cfg_tag  in  48  entry TSN tag.
- ov_tsntag  out  48  descriptor tag.
- ov_bufid  out  9  descriptor buffer id.
- o_hit  out  1  1 = table hit.
- o_descriptor_wr  out  1  descriptor valid, held until ack.
- i_descriptor_ack  in  1  downstream accept.
- ov_drop_cnt  out  16  count of dropped requests.

Function
REQ-003 SHALL implement the FSM states IDLE, SEARCH and OUTPUT.
REQ-004 IDLE: on i_5tuple_data_wr, SHALL register key, dmac, bufid and flag; if flag=1 go to SEARCH with index 0, otherwise go to OUTPUT as a miss.
REQ-005 SEARCH SHALL compare one entry per cycle: index k is compared in cycle T+1+k, where T is the request cycle; hit = valid && key==stored key.
REQ-006 On the first hit (lowest index) SHALL latch tag and set o_hit=1, then go to OUTPUT; remaining entries are not compared.
REQ-007 If index TBL_DEPTH-1 does not hit, SHALL set o_hit=0 and go to OUTPUT.
REQ-008 Miss SHALL give ov_tsntag = registered dmac; hit SHALL give ov_tsntag = entry tag.
REQ-009 OUTPUT: o_descriptor_wr, ov_tsntag, ov_bufid and o_hit SHALL be stable until i_descriptor_ack=1 is sampled; in the next cycle o_descriptor_wr=0 and state=IDLE.
REQ-010 Latency from request to o_descriptor_wr high SHALL be: hit at index k = k+2 cycles; miss = TBL_DEPTH+1 cycles; non-TCP/UDP = 1 cycle.
REQ-011 A request is accepted in IDLE only. A request in SEARCH or OUTPUT SHALL be dropped and SHALL increment ov_drop_cnt, which saturates at 16'hFFFF.
REQ-012 A request in the same cycle as ack SHALL be dropped, because the state is still OUTPUT.
REQ-013 i_cfg_wr SHALL write {valid, key, tag} at iv_cfg_addr in any state, taking effect next cycle.
REQ-014 A config write and a search compare to the same index in the same cycle SHALL compare the old contents.
REQ-015 ov_tsntag, ov_bufid and o_hit SHALL be 0 whenever o_descriptor_wr=0.

Reset
REQ-016 i_rst SHALL set state to IDLE and clear every output, ov_drop_cnt, all entry valid bits and the search index.
REQ-017 Reset mid-SEARCH or mid-OUTPUT SHALL abort the request with no descriptor emitted.

Structure
REQ-018 A shared package SHALL hold the FSM state encodings, the tuple field bit positions, the widths 104/48/9, and the drop-counter maximum.
REQ-019 The table SHALL be the sub-module flow_tbl_regfile: a register file with a synchronous write port and a combinational read port indexed by the search index; all other logic is in one module.

Verification
REQ-020 Entry 3 = {valid, key K, tag 48'h0000_1234_5678}; request K with bufid 9'h05 at cycle T -> o_descriptor_wr high at T+5, tag 48'h0000_1234_5678, bufid 9'h05, o_hit=1.
REQ-021 All entries invalid; TCP request with dmac 48'h0011_2233_4455 -> o_descriptor_wr high at T+9, ov_tsntag=48'h0011_2233_4455, o_hit=0.
REQ-022 Non-TCP/UDP request (flag=0) -> descriptor at T+1, o_hit=0; hold ack low 10 cycles -> outputs stable; ack -> o_descriptor_wr=0 next cycle.
REQ-023 Entries 1 and 6 both = K -> hit returns entry 1 tag at T+3.
REQ-024 Three requests during SEARCH -> ov_drop_cnt=3; preload counter at 16'hFFFE, then drop 3 -> ov_drop_cnt=16'hFFFF.
REQ-025 Reset asserted in SEARCH -> no descriptor emitted, all valid bits cleared; a following request of K -> miss.
